// File: rtl/uart_pkg.sv
// Shared register map, bit positions, FSM encodings and small helpers
// for the APB UART controller.
package uart_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_RXDATA = 4'h2;
  localparam logic [3:0] OFF_BAUD   = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h6;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  localparam int ST_TX_BUSY  = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_RX_FULL  = 4;
  localparam int ST_OVR      = 5;
  localparam int ST_FERR     = 6;

  localparam int CT_TX_EN      = 0;
  localparam int CT_RX_EN      = 1;
  localparam int CT_LOOPBACK   = 2;
  localparam int CT_IRQ_RX_EN  = 3;
  localparam int CT_IRQ_TXE_EN = 4;

  localparam int                CTRL_W     = 5;
  localparam logic [CTRL_W-1:0] CTRL_RESET = 5'b00011;
  localparam logic [15:0]       DIV_MIN    = 16'd1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < DIV_MIN) ? DIV_MIN : div;
  endfunction

  // (DIV+1)/2 - 1, computed in 17 bits so DIV=0xFFFF does not wrap
  function automatic logic [15:0] half_period_m1(input logic [15:0] div);
    logic [16:0] period;
    period = {1'b0, div} + 17'd1;
    return period[16:1] - 16'd1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO used for the UART TX and RX queues.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when a pop frees a slot this cycle
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/apb_uart_ctrl.sv
// APB3 slave UART: TX/RX serialisers with FIFOs, programmable baud divisor,
// sticky overrun/framing flags, loopback and a registered level interrupt.
module apb_uart_ctrl
  import uart_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 16,
  parameter logic [11:0] BASE_ADDR   = 12'h600,
  parameter int          DATA_BITS   = 8,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic                  clk,
  input  logic                  preset,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  output logic                  irq
);

  localparam int             CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  // Register state
  logic [15:0]       div_reg;
  logic [CTRL_W-1:0] ctrl;
  logic              ovr;
  logic              ferr;

  // FIFO interfaces
  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] tx_rdata, rx_rdata;
  logic [CNT_W-1:0]     tx_count_unused, rx_count_unused;

  // APB decode
  logic        access, in_window, mapped, ok;
  logic        sel_tx, sel_rx, sel_baud, sel_stat, sel_ctrl;
  logic        baud_wr, stat_wr, ctrl_wr;
  logic [15:0] status, rd_val;
  logic        unused_paddr;

  // TX datapath
  tx_state_t            tx_state;
  logic [15:0]          tx_cnt, tx_div_act;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_line, tx_busy, tx_start;

  // RX datapath
  rx_state_t            rx_state;
  logic [15:0]          rx_cnt, rx_div_act, rx_half;
  logic [2:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 sync1, sync2, rx_in, rx_prev;
  logic                 rx_stop_done, ovr_set, ferr_set;

  assign pready       = 1'b1;
  assign uart_tx      = tx_line;
  assign unused_paddr = ^paddr[ADDR_WIDTH-1:12];

  assign access    = psel & penable;
  assign in_window = (paddr[11:4] == BASE_ADDR[11:4]);

  always_comb begin
    sel_tx   = 1'b0;
    sel_rx   = 1'b0;
    sel_baud = 1'b0;
    sel_stat = 1'b0;
    sel_ctrl = 1'b0;
    if (in_window) begin
      case (paddr[3:0])
        OFF_TXDATA: sel_tx   = 1'b1;
        OFF_RXDATA: sel_rx   = 1'b1;
        OFF_BAUD:   sel_baud = 1'b1;
        OFF_STATUS: sel_stat = 1'b1;
        OFF_CTRL:   sel_ctrl = 1'b1;
        default:    ;
      endcase
    end
  end

  assign mapped  = sel_tx | sel_rx | sel_baud | sel_stat | sel_ctrl;
  assign pslverr = access & (~mapped | (sel_tx & pwrite & tx_full) | (sel_rx & ~pwrite & rx_empty));
  assign ok      = access & ~pslverr;

  assign tx_push = ok &  pwrite & sel_tx;
  assign rx_pop  = ok & ~pwrite & sel_rx;
  assign baud_wr = ok &  pwrite & sel_baud;
  assign stat_wr = ok &  pwrite & sel_stat;
  assign ctrl_wr = ok &  pwrite & sel_ctrl;

  always_comb begin
    status               = '0;
    status[ST_TX_BUSY]   = tx_busy;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_EMPTY]  = tx_empty;
    status[ST_RX_EMPTY]  = rx_empty;
    status[ST_RX_FULL]   = rx_full;
    status[ST_OVR]       = ovr;
    status[ST_FERR]      = ferr;
  end

  always_comb begin
    rd_val = '0;
    if (ok & ~pwrite) begin
      if (sel_rx)   rd_val[DATA_BITS-1:0] = rx_rdata;
      if (sel_baud) rd_val = div_reg;
      if (sel_stat) rd_val = status;
      if (sel_ctrl) rd_val[CTRL_W-1:0] = ctrl;
    end
    prdata       = '0;
    prdata[15:0] = rd_val;
  end

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (preset),
    .push  (tx_push),
    .wdata (pwdata[DATA_BITS-1:0]),
    .pop   (tx_pop),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count_unused)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (preset),
    .push  (rx_push),
    .wdata (rx_shift),
    .pop   (rx_pop),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count_unused)
  );

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      div_reg <= DEFAULT_DIV;
      ctrl    <= CTRL_RESET;
      ovr     <= 1'b0;
      ferr    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (baud_wr) div_reg <= clamp_div(pwdata[15:0]);
      if (ctrl_wr) ctrl    <= pwdata[CTRL_W-1:0];
      // A set event in the same cycle as a W1C write keeps the flag set
      if (ovr_set)                       ovr  <= 1'b1;
      else if (stat_wr & pwdata[ST_OVR]) ovr  <= 1'b0;
      if (ferr_set)                       ferr <= 1'b1;
      else if (stat_wr & pwdata[ST_FERR]) ferr <= 1'b0;
      irq <= (ctrl[CT_IRQ_RX_EN] & ~rx_empty) |
             (ctrl[CT_IRQ_TXE_EN] & tx_empty & ~tx_busy) | ovr | ferr;
    end
  end

  // A new frame may start from IDLE or straight out of the last STOP cycle
  assign tx_busy  = (tx_state != TX_IDLE);
  assign tx_start = ctrl[CT_TX_EN] & ~tx_empty &
                    ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & (tx_cnt == tx_div_act)));
  assign tx_pop   = tx_start;

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_div_act <= DEFAULT_DIV;
      tx_bit     <= '0;
      tx_shift   <= '0;
      tx_line    <= 1'b1;
    end else if (tx_start) begin
      tx_state   <= TX_START;
      tx_cnt     <= '0;
      tx_div_act <= div_reg;
      tx_shift   <= tx_rdata;
      tx_line    <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: tx_line <= 1'b1;
        TX_START:
          if (tx_cnt == tx_div_act) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
            tx_state <= TX_DATA;
          end else tx_cnt <= tx_cnt + 16'd1;
        TX_DATA:
          if (tx_cnt == tx_div_act) begin
            tx_cnt <= '0;
            if (tx_bit == LAST_BIT) begin
              tx_line  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= tx_shift >> 1;
              tx_line  <= tx_shift[1];
            end
          end else tx_cnt <= tx_cnt + 16'd1;
        TX_STOP:
          if (tx_cnt == tx_div_act) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else tx_cnt <= tx_cnt + 16'd1;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Loopback taps the internal TX line directly, bypassing the synchroniser
  assign rx_in        = ctrl[CT_LOOPBACK] ? tx_line : sync2;
  assign rx_stop_done = (rx_state == RX_STOP) & (rx_cnt == rx_div_act);
  assign ferr_set     = rx_stop_done & ~rx_in;
  assign ovr_set      = rx_stop_done & rx_in & rx_full;
  assign rx_push      = rx_stop_done & rx_in & ~rx_full;

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_div_act <= DEFAULT_DIV;
      rx_half    <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
    end else begin
      sync1   <= uart_rx;
      sync2   <= sync1;
      rx_prev <= rx_in;
      case (rx_state)
        RX_IDLE:
          if (ctrl[CT_RX_EN] & rx_prev & ~rx_in) begin
            rx_state   <= RX_START;
            rx_cnt     <= '0;
            rx_div_act <= div_reg;
            rx_half    <= half_period_m1(div_reg);
          end
        RX_START:
          if (rx_cnt == rx_half) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_in ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + 16'd1;
        RX_DATA:
          if (rx_cnt == rx_div_act) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_in, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) rx_state <= RX_STOP;
            else                    rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt + 16'd1;
        RX_STOP:
          if (rx_cnt == rx_div_act) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else rx_cnt <= rx_cnt + 16'd1;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_ctrl.sv
// Directed self-checking bench for apb_uart_ctrl.
module tb_apb_uart_ctrl;

  logic        clk = 1'b0;
  logic        preset;
  logic [31:0] paddr;
  logic        psel, penable, pwrite;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready, pslverr;
  logic        uart_rx, uart_tx, irq;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  apb_uart_ctrl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (16),
    .BASE_ADDR  (12'h600),
    .DATA_BITS  (8),
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd433)
  ) dut (
    .clk     (clk),
    .preset  (preset),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .irq     (irq)
  );

  task automatic apb_write(input logic [31:0] addr, input logic [15:0] data, output logic err);
    @(negedge clk);
    paddr = addr; pwdata = data; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [15:0] data, output logic err);
    @(negedge clk);
    paddr = addr; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 data = prdata; err = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk); uart_rx = 1'b0; repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); uart_rx = b[i]; repeat (3) @(negedge clk);
    end
    @(negedge clk); uart_rx = stop_bit; repeat (3) @(negedge clk);
    @(negedge clk); uart_rx = 1'b1; repeat (5) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [15:0] d; logic e; logic found;
    total++; if ({uart_tx, irq, pslverr, prdata} !== {1'b1, 1'b0, 1'b0, 16'h0})
      $display("FAIL reset_pins: got tx=%b irq=%b err=%b rd=%h", uart_tx, irq, pslverr, prdata); else passed++;
    apb_read(32'h606, d, e);
    total++; if (d !== 16'h000C) $display("FAIL reset_status: got %h expected 000c", d); else passed++;
    apb_read(32'h608, d, e);
    total++; if (d !== 16'h0003) $display("FAIL reset_ctrl: got %h expected 0003", d); else passed++;
    apb_read(32'h604, d, e);
    total++; if (d !== 16'd433) $display("FAIL reset_baud: got %0d expected 433", d); else passed++;
    apb_write(32'h604, 16'd3, e);
    apb_write(32'h600, 16'h55, e);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (uart_tx == 1'b0) found = 1'b1;
    end
    total++; if (found !== 1'b1) $display("FAIL reset_start_seen: got %b expected 1", found); else passed++;
    preset = 1'b1;
    #1;
    total++; if (uart_tx !== 1'b1) $display("FAIL reset_midframe_tx: got %b expected 1", uart_tx); else passed++;
    repeat (2) @(negedge clk);
    preset = 1'b0;
    apb_read(32'h606, d, e);
    total++; if (d !== 16'h000C) $display("FAIL reset_midframe_status: got %h expected 000c", d); else passed++;
    apb_read(32'h608, d, e);
    total++; if (d !== 16'h0003) $display("FAIL reset_midframe_ctrl: got %h expected 0003", d); else passed++;
  endtask

  task automatic test_tx_timing;
    logic [15:0] d; logic e; logic found;
    logic exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int bad;
    apb_write(32'h604, 16'd3, e);
    apb_read(32'h604, d, e);
    total++; if (d !== 16'd3) $display("FAIL tx_baud_rb: got %0d expected 3", d); else passed++;
    apb_write(32'h600, 16'h55, e);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (uart_tx == 1'b0) found = 1'b1;
    end
    total++; if (found !== 1'b1) $display("FAIL tx_start_timeout: got %b expected 1", found); else passed++;
    for (int s = 0; s < 10; s++) begin
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        if (s != 0 || c != 0) @(negedge clk);
        if (uart_tx !== exp_bits[s]) bad++;
      end
      total++; if (bad != 0) $display("FAIL tx_slot%0d: %0d of 4 samples differ from %b", s, bad, exp_bits[s]); else passed++;
    end
    @(negedge clk);
    total++; if (uart_tx !== 1'b1) $display("FAIL tx_after_frame: got %b expected 1", uart_tx); else passed++;
    apb_write(32'h600, 16'h00, e);
    apb_read(32'h606, d, e);
    total++; if (d !== 16'h000D) $display("FAIL tx_busy_status: got %h expected 000d", d); else passed++;
    repeat (50) @(negedge clk);
    apb_read(32'h606, d, e);
    total++; if (d !== 16'h000C) $display("FAIL tx_idle_status: got %h expected 000c", d); else passed++;
  endtask

  task automatic test_loopback;
    logic [15:0] d; logic e;
    apb_write(32'h608, 16'h000F, e);
    apb_write(32'h600, 16'h00A5, e);
    apb_write(32'h600, 16'h003C, e);
    repeat (120) @(negedge clk);
    total++; if (irq !== 1'b1) $display("FAIL lb_irq_high: got %b expected 1", irq); else passed++;
    apb_read(32'h606, d, e);
    total++; if (d !== 16'h0004) $display("FAIL lb_status: got %h expected 0004", d); else passed++;
    apb_read(32'h602, d, e);
    total++; if ({e, d} !== {1'b0, 16'h00A5}) $display("FAIL lb_rd1: got err=%b %h expected 0 00a5", e, d); else passed++;
    apb_read(32'h602, d, e);
    total++; if ({e, d} !== {1'b0, 16'h003C}) $display("FAIL lb_rd2: got err=%b %h expected 0 003c", e, d); else passed++;
    apb_read(32'h602, d, e);
    total++; if ({e, d} !== {1'b1, 16'h0000}) $display("FAIL lb_rd_empty: got err=%b %h expected 1 0000", e, d); else passed++;
    @(negedge clk);
    total++; if (irq !== 1'b0) $display("FAIL lb_irq_low: got %b expected 0", irq); else passed++;
  endtask

  task automatic test_tx_overflow;
    logic [15:0] d; logic e; int errs;
    apb_write(32'h608, 16'h0002, e);
    errs = 0;
    for (int i = 1; i <= 8; i++) begin
      apb_write(32'h600, 16'(i), e);
      if (e) errs++;
    end
    total++; if (errs != 0) $display("FAIL ovf_first8_err: got %0d errors expected 0", errs); else passed++;
    apb_write(32'h600, 16'h0009, e);
    total++; if (e !== 1'b1) $display("FAIL ovf_9th_err: got %b expected 1", e); else passed++;
    apb_read(32'h606, d, e);
    total++; if (d !== 16'h000A) $display("FAIL ovf_status: got %h expected 000a", d); else passed++;
    apb_write(32'h608, 16'h0007, e);
    repeat (400) @(negedge clk);
    apb_read(32'h606, d, e);
    total++; if (d !== 16'h0014) $display("FAIL ovf_drained_status: got %h expected 0014", d); else passed++;
    for (int i = 1; i <= 8; i++) begin
      apb_read(32'h602, d, e);
      total++; if ({e, d} !== {1'b0, 16'(i)}) $display("FAIL ovf_frame%0d: got err=%b %h expected 0 %h", i, e, d, 16'(i)); else passed++;
    end
    apb_read(32'h602, d, e);
    total++; if (e !== 1'b1) $display("FAIL ovf_no_9th_frame: got err=%b expected 1", e); else passed++;
  endtask

  task automatic test_rx_errors;
    logic [15:0] d; logic e;
    logic [7:0] vec [9] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h77};
    apb_write(32'h608, 16'h0003, e);
    for (int i = 0; i < 9; i++) send_frame(vec[i], 1'b1);
    repeat (20) @(negedge clk);
    apb_read(32'h606, d, e);
    total++; if (d !== 16'h0034) $display("FAIL rx_ovr_status: got %h expected 0034", d); else passed++;
    total++; if (irq !== 1'b1) $display("FAIL rx_ovr_irq: got %b expected 1", irq); else passed++;
    for (int i = 0; i < 8; i++) begin
      apb_read(32'h602, d, e);
      total++; if ({e, d} !== {1'b0, 8'h00, vec[i]}) $display("FAIL rx_byte%0d: got err=%b %h expected 0 %h", i, e, d, vec[i]); else passed++;
    end
    send_frame(8'h42, 1'b0);
    repeat (20) @(negedge clk);
    apb_read(32'h606, d, e);
    total++; if (d !== 16'h006C) $display("FAIL rx_ferr_status: got %h expected 006c", d); else passed++;
    apb_write(32'h606, 16'h0060, e);
    apb_read(32'h606, d, e);
    total++; if (d !== 16'h000C) $display("FAIL rx_w1c_status: got %h expected 000c", d); else passed++;
    repeat (2) @(negedge clk);
    total++; if (irq !== 1'b0) $display("FAIL rx_irq_cleared: got %b expected 0", irq); else passed++;
  endtask

  task automatic test_baud_clamp;
    logic [15:0] d; logic e;
    apb_write(32'h604, 16'd0, e);
    apb_read(32'h604, d, e);
    total++; if (d !== 16'd1) $display("FAIL baud_clamp: got %0d expected 1", d); else passed++;
    apb_write(32'h604, 16'd3, e);
    apb_read(32'h604, d, e);
    total++; if (d !== 16'd3) $display("FAIL baud_restore: got %0d expected 3", d); else passed++;
  endtask

  task automatic test_decode_glitch;
    logic [15:0] d; logic e;
    apb_write(32'h60A, 16'hFFFF, e);
    total++; if (e !== 1'b1) $display("FAIL dec_60a_wr: got err=%b expected 1", e); else passed++;
    apb_read(32'h60A, d, e);
    total++; if ({e, d} !== {1'b1, 16'h0}) $display("FAIL dec_60a_rd: got err=%b %h expected 1 0000", e, d); else passed++;
    apb_write(32'h700, 16'h0011, e);
    total++; if (e !== 1'b1) $display("FAIL dec_700_wr: got err=%b expected 1", e); else passed++;
    apb_write(32'h704, 16'h0009, e);
    apb_read(32'h604, d, e);
    total++; if (d !== 16'd3) $display("FAIL dec_baud_unchanged: got %0d expected 3", d); else passed++;
    apb_read(32'h600, d, e);
    total++; if ({e, d} !== {1'b0, 16'h0}) $display("FAIL dec_txdata_rd: got err=%b %h expected 0 0000", e, d); else passed++;
    apb_write(32'h602, 16'h00AA, e);
    total++; if (e !== 1'b0) $display("FAIL dec_rxdata_wr: got err=%b expected 0", e); else passed++;
    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b1;
    repeat (60) @(negedge clk);
    apb_read(32'h606, d, e);
    total++; if (d !== 16'h000C) $display("FAIL glitch_status: got %h expected 000c", d); else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    preset = 1'b0;
    @(negedge clk);
    test_reset;
    test_tx_timing;
    test_loopback;
    test_tx_overflow;
    test_rx_errors;
    test_baud_clamp;
    test_decode_glitch;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
